keypad_key_emulator: RTL

- Drives the row side of a 4x4 matrix keypad interface: presents key presses to the on-chip keypad Decoder, or to an external scanner, from a queued stream of 4-bit key codes.
- Responds to the scanner's active-low column strobes with active-low row lines, as a physical Pmod keypad would.
- Used as a synthesizable keypad emulator for self-test and for bench stimulus of the keypad/linear-regression entry path.
- Codes 4'hE (enter) and 4'hD (input_done) are ordinary keys here.

---
 rtl/keypad_key_emulator.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_key_emulator.sv
// keypad_key_emulator: emulates the row side of a 4x4 matrix keypad.
// Key codes are queued in a small FIFO and played back as timed presses.
//
// Ports:
//   clock, reset    system clock; asynchronous active-high reset
//   key_code        key to press (0x0..0xF)
//   key_valid       key_code valid; accepted when key_ready is high
//   key_ready       FIFO not full
//   col_n           active-low column strobes from the scanner (bit0 = left)
//   row_n           active-low row lines to the scanner (bit0 = top)
//   busy            a press is in progress or keys are queued
//   key_done        one-cycle pulse after each press/release sequence
//   fifo_count      number of queued key codes
//
// Build option: define KEYPAD_BOUNCE_EN to add contact bounce at the start
// of each press (BOUNCE_CYCLES / BOUNCE_PERIOD). Without it the contact is
// clean and the bounce parameters generate no logic.

module keypad_key_emulator #(
    parameter int HOLD_CYCLES    = 2000,
    parameter int RELEASE_CYCLES = 2000,
    parameter int FIFO_DEPTH     = 4,
    parameter int BOUNCE_CYCLES  = 16,
    parameter int BOUNCE_PERIOD  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [3:0]                    key_code,
    input  logic                          key_valid,
    output logic                          key_ready,
    input  logic [3:0]                    col_n,
    output logic [3:0]                    row_n,
    output logic                          busy,
    output logic                          key_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNTW    = AW + 1;
    localparam int CNT_MAX = (HOLD_CYCLES > RELEASE_CYCLES) ?
                             HOLD_CYCLES : RELEASE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]   REL_LAST  = CW'(RELEASE_CYCLES - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESS   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    if (HOLD_CYCLES < 1 || RELEASE_CYCLES < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BOUNCE_CYCLES < 0 ||
        BOUNCE_PERIOD < 1 ||
        (BOUNCE_PERIOD & (BOUNCE_PERIOD - 1)) != 0) begin : g_param_check
        $error("keypad_key_emulator: illegal parameter value");
    end

    // FIFO state
    logic [3:0]      mem_q [FIFO_DEPTH];
    logic [3:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;

    // Press sequencer state
    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      cur_key_q, cur_key_d;
    logic            key_done_q, key_done_d;
    logic [3:0]      row_n_q, row_n_d;

    logic            push;
    logic            pop;
    logic            contact;
    logic [1:0]      key_row;
    logic [1:0]      key_col;

    assign key_ready  = (count_q != FULL_CNT);
    assign push       = key_valid && key_ready;
    assign pop        = (state_q == S_IDLE) && (count_q != '0);
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign key_done   = key_done_q;
    assign fifo_count = count_q;
    assign row_n      = row_n_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = key_code;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Transitions fire at the terminal count, so the counter never wraps.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_key_d  = cur_key_q;
        key_done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cur_key_d = mem_q[rd_ptr_q];
                    cnt_d     = '0;
                    state_d   = S_PRESS;
                end
            end
            S_PRESS: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (cnt_q == REL_LAST) begin
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                    key_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Physical position of the current key on the Pmod keypad.
    always_comb begin
        key_row = 2'd0;
        key_col = 2'd0;
        case (cur_key_q)
            4'h1: begin key_row = 2'd0; key_col = 2'd0; end
            4'h2: begin key_row = 2'd0; key_col = 2'd1; end
            4'h3: begin key_row = 2'd0; key_col = 2'd2; end
            4'hA: begin key_row = 2'd0; key_col = 2'd3; end
            4'h4: begin key_row = 2'd1; key_col = 2'd0; end
            4'h5: begin key_row = 2'd1; key_col = 2'd1; end
            4'h6: begin key_row = 2'd1; key_col = 2'd2; end
            4'hB: begin key_row = 2'd1; key_col = 2'd3; end
            4'h7: begin key_row = 2'd2; key_col = 2'd0; end
            4'h8: begin key_row = 2'd2; key_col = 2'd1; end
            4'h9: begin key_row = 2'd2; key_col = 2'd2; end
            4'hC: begin key_row = 2'd2; key_col = 2'd3; end
            4'h0: begin key_row = 2'd3; key_col = 2'd0; end
            4'hF: begin key_row = 2'd3; key_col = 2'd1; end
            4'hE: begin key_row = 2'd3; key_col = 2'd2; end
            4'hD: begin key_row = 2'd3; key_col = 2'd3; end
            default: begin key_row = 2'd0; key_col = 2'd0; end
        endcase
    end

`ifdef KEYPAD_BOUNCE_EN
    localparam int unsigned BOUNCE_LEN =
        (BOUNCE_CYCLES < HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int BP_SHIFT = $clog2(BOUNCE_PERIOD);

    // Early in the press the contact alternates closed/open every
    // BOUNCE_PERIOD cycles, starting closed.
    always_comb begin
        contact = (state_q == S_PRESS);
        if ((32'(cnt_q) < BOUNCE_LEN) &&
            (((32'(cnt_q) >> BP_SHIFT) & 32'd1) == 32'd1)) begin
            contact = 1'b0;
        end
    end
`else
    assign contact = (state_q == S_PRESS);
`endif

    // Only the key's own column strobe matters; other columns are ignored.
    always_comb begin
        row_n_d = 4'hF;
        if (contact && !col_n[key_col]) begin
            row_n_d[key_row] = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 4'h0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cur_key_q  <= 4'h0;
            key_done_q <= 1'b0;
            row_n_q    <= 4'hF;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_key_q  <= cur_key_d;
            key_done_q <= key_done_d;
            row_n_q    <= row_n_d;
        end
    end

endmodule
